// File: rtl/alu_req_driver.sv
// rtl/alu_req_driver.sv - initiator side of the 32-bit ALU operand/function interface
//
// Accepts tagged operation requests, registers them into a single issue stage
// that drives the external combinational ALU, captures the result into a small
// response FIFO and returns it in request order. An accumulator holds the last
// legal result so that requests can chain on it without a round trip.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   req_*           request handshake: function, op1, op2, use_acc, tag
//   acc_clear       zero the accumulator at the edge
//   alu_input1/2    ALU operands (0 when nothing is issuing)
//   alu_function    ALU function code (0 when idle or illegal)
//   alu_output      ALU combinational result
//   rsp_*           response handshake: data, tag, illegal flag (FIFO head)

module alu_req_driver #(
    parameter int RSP_DEPTH = 2,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_function,
    input  logic [31:0]       req_op1,
    input  logic [31:0]       req_op2,
    input  logic              req_use_acc,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              acc_clear,

    output logic [31:0]       alu_input1,
    output logic [31:0]       alu_input2,
    output logic [4:0]        alu_function,
    input  logic [31:0]       alu_output,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_illegal
);

    localparam int PTR_W   = $clog2(RSP_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + TAG_W + 1;

    // Highest legal function code (sltu).
    localparam logic [4:0] FN_MAX = 5'd9;

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------
    logic              s1_valid;
    logic [4:0]        s1_function;
    logic [31:0]       s1_op1;
    logic [31:0]       s1_op2;
    logic              s1_use_acc;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_illegal;

    logic [31:0]       acc;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic               accept;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   occupancy;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Credit rule: every op in the issue stage already owns a FIFO slot, so
    // a capture can never find the FIFO full. Only registered state is used,
    // keeping req_ready free of any combinational path from the consumer.
    always_comb begin
        occupancy = fifo_count + CNT_W'(s1_valid);
        req_ready = !rst && (occupancy < CNT_W'(RSP_DEPTH));
    end

    always_comb begin
        accept = req_valid && req_ready;
        push   = s1_valid;
        pop    = rsp_valid && rsp_ready;
    end

    // ALU drive: everything reads 0 while idle or in reset; illegal codes are
    // presented to the ALU as add so it never sees an undefined function.
    always_comb begin
        alu_input1   = 32'd0;
        alu_input2   = 32'd0;
        alu_function = 5'd0;
        if (!rst && s1_valid) begin
            alu_input1   = s1_use_acc ? acc : s1_op1;
            alu_input2   = s1_op2;
            alu_function = s1_illegal ? 5'd0 : s1_function;
        end
    end

    always_comb begin
        push_entry = {(s1_illegal ? 32'd0 : alu_output), s1_tag, s1_illegal};
        head_entry = fifo_mem[rd_ptr];
    end

    // Control state with reset: issue valid, pointers, count, accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            acc        <= 32'd0;
        end else begin
            s1_valid <= accept;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end

            // Clear wins over a same-edge capture; the issuing op has already
            // read the pre-edge accumulator value.
            if (acc_clear) begin
                acc <= 32'd0;
            end else if (s1_valid && !s1_illegal) begin
                acc <= alu_output;
            end
        end
    end

    // Payload registers carry no reset: they are only observed while the
    // matching valid bit (s1_valid / fifo occupancy) is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_function <= req_function;
            s1_op1      <= req_op1;
            s1_op2      <= req_op2;
            s1_use_acc  <= req_use_acc;
            s1_tag      <= req_tag;
            s1_illegal  <= (req_function > FN_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // Response outputs read 0 whenever no entry is presented.
    always_comb begin
        rsp_valid   = !rst && (fifo_count != '0);
        rsp_data    = 32'd0;
        rsp_tag     = '0;
        rsp_illegal = 1'b0;
        if (rsp_valid) begin
            rsp_data    = head_entry[ENTRY_W-1 -: 32];
            rsp_tag     = head_entry[TAG_W:1];
            rsp_illegal = head_entry[0];
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// tb/tb_alu_req_driver.sv - scoreboard testbench for alu_req_driver

module tb_alu_req_driver;

    localparam int RSP_DEPTH = 2;
    localparam int TAG_W     = 4;

    localparam logic [4:0] F_ADD  = 5'd0;
    localparam logic [4:0] F_SLL  = 5'd1;
    localparam logic [4:0] F_XOR  = 5'd2;
    localparam logic [4:0] F_SRL  = 5'd3;
    localparam logic [4:0] F_OR   = 5'd4;
    localparam logic [4:0] F_AND  = 5'd5;
    localparam logic [4:0] F_SUB  = 5'd6;
    localparam logic [4:0] F_SRA  = 5'd7;
    localparam logic [4:0] F_SLT  = 5'd8;
    localparam logic [4:0] F_SLTU = 5'd9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_function = '0;
    logic [31:0]      req_op1 = '0;
    logic [31:0]      req_op2 = '0;
    logic             req_use_acc = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             acc_clear = 1'b0;
    logic [31:0]      alu_input1;
    logic [31:0]      alu_input2;
    logic [4:0]       alu_function;
    logic [31:0]      alu_output;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_illegal;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_req_driver #(.RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_function (req_function),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_use_acc  (req_use_acc),
        .req_tag      (req_tag),
        .acc_clear    (acc_clear),
        .alu_input1   (alu_input1),
        .alu_input2   (alu_input2),
        .alu_function (alu_function),
        .alu_output   (alu_output),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_illegal  (rsp_illegal)
    );

    // External combinational ALU
    always_comb begin
        alu_output = 32'd0;
        case (alu_function)
            F_ADD:  alu_output = alu_input1 + alu_input2;
            F_SLL:  alu_output = alu_input1 << alu_input2[4:0];
            F_XOR:  alu_output = alu_input1 ^ alu_input2;
            F_SRL:  alu_output = alu_input1 >> alu_input2[4:0];
            F_OR:   alu_output = alu_input1 | alu_input2;
            F_AND:  alu_output = alu_input1 & alu_input2;
            F_SUB:  alu_output = alu_input1 - alu_input2;
            F_SRA:  alu_output = $unsigned($signed(alu_input1) >>> alu_input2[4:0]);
            F_SLT:  alu_output = {31'd0, $signed(alu_input1) < $signed(alu_input2)};
            F_SLTU: alu_output = {31'd0, alu_input1 < alu_input2};
            default: alu_output = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every handshaken response is compared against the queue head.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {28'd0, rsp_tag}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
                check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
            end
        end
    end

    // Offers one request; returns at #1 after the accepting edge.
    task automatic send(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic ua, input logic [TAG_W-1:0] t,
                        input logic [31:0] ed, input logic ei);
        int n;
        exp_t e;
        req_valid    = 1'b1;
        req_function = f;
        req_op1      = a;
        req_op2      = b;
        req_use_acc  = ua;
        req_tag      = t;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                check("req_accept_timeout", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        e.data = ed;
        e.tag  = t;
        e.ill  = ei;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_alu_in1", alu_input1, 32'd0);
        check("rst_alu_fn", {27'd0, alu_function}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // First request, latency and issue-cycle ALU drive
        send(F_ADD, 32'd5, 32'd7, 1'b0, 4'd3, 32'd12, 1'b0);
        @(negedge clk);
        check("issue_in1", alu_input1, 32'd5);
        check("issue_in2", alu_input2, 32'd7);
        check("issue_fn", {27'd0, alu_function}, 32'd0);
        check("lat_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("lat_rsp_data", rsp_data, 32'd12);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // Operator sweep
        send(F_SRA,  32'h8000_0000, 32'd4,    1'b0, 4'd1, 32'hF800_0000, 1'b0);
        send(F_SRL,  32'h8000_0000, 32'd4,    1'b0, 4'd2, 32'h0800_0000, 1'b0);
        send(F_SLT,  32'hFFFF_FFFF, 32'd1,    1'b0, 4'd3, 32'd1,         1'b0);
        send(F_SLTU, 32'hFFFF_FFFF, 32'd1,    1'b0, 4'd4, 32'd0,         1'b0);
        send(F_SLL,  32'd1,         32'h21,   1'b0, 4'd5, 32'd2,         1'b0);
        send(F_XOR,  32'hF0F0,      32'hFF00, 1'b0, 4'd6, 32'h0FF0,      1'b0);
        send(F_AND,  32'hF0F0,      32'hFF00, 1'b0, 4'd7, 32'hF000,      1'b0);
        drain();

        // Accumulator chain
        send(F_ADD, 32'd10,   32'd0,  1'b0, 4'd8,  32'd10,        1'b0);
        send(F_ADD, 32'hAAAA, 32'd5,  1'b1, 4'd9,  32'd15,        1'b0);
        send(F_SUB, 32'hAAAA, 32'd20, 1'b1, 4'd10, 32'hFFFF_FFFB, 1'b0);
        drain();
        @(posedge clk);
        #1;
        acc_clear = 1'b1;
        @(posedge clk);
        #1;
        acc_clear = 1'b0;
        send(F_OR, 32'h1234, 32'd0, 1'b1, 4'd11, 32'd0, 1'b0);
        drain();

        // acc_clear during an issuing op: op sees old acc, clear wins the edge
        send(F_ADD, 32'd3, 32'd4, 1'b0, 4'd12, 32'd7, 1'b0);
        acc_clear = 1'b1;
        @(posedge clk);
        #1;
        acc_clear = 1'b0;
        send(F_ADD, 32'h5555, 32'd0, 1'b1, 4'd13, 32'd0, 1'b0);
        drain();

        // Backpressure
        rsp_ready = 1'b0;
        send(F_ADD, 32'd1, 32'd1, 1'b0, 4'd4, 32'd2, 1'b0);
        send(F_ADD, 32'd2, 32'd2, 1'b0, 4'd5, 32'd4, 1'b0);
        req_valid    = 1'b1;
        req_function = F_ADD;
        req_op1      = 32'd3;
        req_op2      = 32'd3;
        req_use_acc  = 1'b0;
        req_tag      = 4'd6;
        begin
            int hits;
            hits = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (req_ready) hits++;
            end
            check("bp_ready_held_low", hits, 32'd0);
        end
        check("bp_head_tag", {28'd0, rsp_tag}, 32'd4);
        check("bp_head_data", rsp_data, 32'd2);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(F_ADD, 32'd3, 32'd3, 1'b0, 4'd6, 32'd6, 1'b0);
        send(F_ADD, 32'd4, 32'd4, 1'b0, 4'd7, 32'd8, 1'b0);
        drain();

        // Illegal code between two adds
        send(F_ADD, 32'd100, 32'd23, 1'b0, 4'd1, 32'd123, 1'b0);
        send(5'h1F, 32'd5,   32'd6,  1'b0, 4'd2, 32'd0,   1'b1);
        send(F_ADD, 32'd0,   32'd1,  1'b1, 4'd3, 32'd124, 1'b0);
        drain();

        // Reset with one response buffered and one op issuing
        rsp_ready = 1'b0;
        send(F_ADD, 32'd40, 32'd2, 1'b0, 4'd14, 32'd42, 1'b0);
        send(F_ADD, 32'd50, 32'd5, 1'b0, 4'd15, 32'd55, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_alu_in1", alu_input1, 32'd0);
        check("rst_mid_alu_in2", alu_input2, 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (rsp_valid) stale++;
            end
            check("rst_no_stale_rsp", stale, 32'd0);
        end
        @(posedge clk);
        #1;
        send(F_ADD, 32'h7777, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
